instruction_fetch: RTL and testbench
====================================

// Module: instruction_fetch
// PURPOSE
//   Requester side of the instruction-memory read port. Generates the fetch PC,
//   drives the word-aligned request address every cycle and pairs each returned
//   instruction with its PC for decode. Handles the fixed 1-cycle synchronous
//   read latency, downstream stalls (by replaying the request) and branch/jump
//   redirects, with no skid buffer. Sits between the PC/branch logic and decode.
// PARAMETERS
//   RESET_PC   0   fetch address after reset; must be 4-byte aligned
// PORTS
//   clk              in   1         clock, all state on posedge
//   rst              in   1         synchronous, active-high reset
//   i_stall          in   1         decode cannot accept o_instr this cycle
//   i_redirect       in   1         taken branch/jump, comb same-cycle
//   i_redirect_pc    in   ADDR_W    redirect target, bits [1:0] ignored
//   o_req_addr       out  ADDR_W    to memory request address, comb
//   i_res_data       in   INSTR_W   memory data for previous cycle's o_req_addr
//   o_instr          out  INSTR_W   instruction to decode, NOP when !o_valid
//   o_pc             out  ADDR_W    PC of o_instr
//   o_valid          out  1         o_instr/o_pc hold a real fetched instruction
// BEHAVIOUR
//   Clock and reset: one clock, clk. rst is synchronous and active-high.
//   State registers:
//     r_pc     next address to request
//     r_f1_pc  address requested last cycle
//     r_f1_vld flags r_f1_pc as a real request
//     r_state  BOOT or RUN
//   Reset (rst=1 at posedge): r_pc<=RESET_PC, r_f1_pc<=RESET_PC, r_f1_vld<=0,
//     r_state<=BOOT. While rst=1: o_valid=0, o_instr=NOP (addi x0,x0,0),
//     o_pc=RESET_PC, o_req_addr=RESET_PC.
//     Reset mid-stream discards the in-flight fetch.
//   Outputs:
//     o_pc=r_f1_pc.
//     o_valid = r_f1_vld & !i_redirect & !rst.
//     o_instr = o_valid ? i_res_data : NOP.
//   Request mux, priority high to low:
//     i_redirect            -> {i_redirect_pc[ADDR_W-1:2],2'b00}
//     i_stall & r_f1_vld    -> r_f1_pc (replay, so memory re-returns held instr)
//     otherwise             -> r_pc
//   Next state for the mux choice. Every update uses a = aligned o_req_addr:
//     r_f1_pc<=a, r_f1_vld<=1, r_pc<=a+4 (wraps mod 2^ADDR_W)
//     redirect: r_pc=target+4, so the redirect has zero bubble.
//     replay: r_f1 is unchanged and r_pc holds.
//   i_stall with o_valid=0 is ignored: bubbles are never held.
//   Redirect outranks stall. The wrong-path o_instr in the redirect cycle is
//     squashed (o_valid=0).
//   FSM:
//     BOOT -> RUN on first cycle with rst=0; BOOT issues RESET_PC.
//     RUN stays in RUN; only rst returns to BOOT.
//     r_f1_vld=1 in every cycle after the first non-reset cycle.
//   Latency: address presented in cycle N appears on o_instr in cycle N+1.
//   Throughput: 1 instr/cycle absent stalls and redirects.
//   Width rules:
//     o_req_addr[1:0] always 2'b00.
//     The fetch unit does no range check; the memory returns NOP past its end.
// TESTING
//   1 reset: rst for 3 cycles, RESET_PC=0, mem[k]=k+1. First cycle out of reset
//     o_req_addr=0, o_valid=0. Then cycles give (pc,instr) = (0,1),(4,2),(8,3).
//   2 stall: assert i_stall for 3 cycles while o_pc=8. o_pc=8, instr=3, o_valid=1
//     and o_req_addr=8 all held. Release -> next cycle o_pc=0xC, instr=4.
//   3 redirect: i_redirect=1 with i_redirect_pc=0x40 while o_pc=4. That cycle
//     o_valid=0, o_req_addr=0x40. Next cycle o_pc=0x40, then 0x44.
//     Repeat with target 0x43 -> o_req_addr=0x40.
//   4 redirect+stall same cycle: redirect wins, o_req_addr=target.
//     A stall held through the next cycle holds o_pc=target.
//   5 wrap: RESET_PC=2^ADDR_W-8. Sequence yields o_pc=..F8,..FC,0,4 with no
//     glitch on o_valid.
//   6 reset mid-stall: rst during stall -> o_valid=0 next cycle. Fetch restarts
//     at RESET_PC per scenario 1.

Source files
------------

// File: rtl/instruction_fetch.sv
// Instruction fetch requester: drives the word-aligned fetch address every cycle
// and pairs each 1-cycle-late memory return with its PC. Stalls replay the request.
module instruction_fetch #(
  parameter int                 ADDR_W   = 32,
  parameter int                 INSTR_W  = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_stall,
  input  logic               i_redirect,
  input  logic [ADDR_W-1:0]  i_redirect_pc,
  output logic [ADDR_W-1:0]  o_req_addr,
  input  logic [INSTR_W-1:0] i_res_data,
  output logic [INSTR_W-1:0] o_instr,
  output logic [ADDR_W-1:0]  o_pc,
  output logic               o_valid
);

  localparam logic [INSTR_W-1:0] NOP = INSTR_W'(32'h0000_0013);

  typedef enum logic {BOOT, RUN} state_t;

  state_t            r_state, state_nxt;
  logic              boot;
  logic [ADDR_W-1:0] r_pc, r_f1_pc;
  logic              r_f1_vld;
  logic [ADDR_W-1:0] redir_addr, req;
  logic              replay;

  always_ff @(posedge clk) begin
    if (rst) r_state <= BOOT;
    else     r_state <= state_nxt;
  end

  always_comb begin
    state_nxt = r_state;
    case (r_state)
      BOOT:    state_nxt = RUN;
      RUN:     state_nxt = RUN;
      default: state_nxt = BOOT;
    endcase
  end

  always_comb begin
    boot = 1'b0;
    case (r_state)
      BOOT:    boot = 1'b1;
      default: boot = 1'b0;
    endcase
  end

  assign redir_addr = {i_redirect_pc[ADDR_W-1:2], 2'b00};
  // Only a real held instruction is replayed; stalling a bubble is meaningless.
  assign replay     = i_stall & r_f1_vld & ~i_redirect;

  always_comb begin
    req = r_pc;
    if (rst)             req = RESET_PC;
    else if (i_redirect) req = redir_addr;
    else if (replay)     req = r_f1_pc;
    else if (boot)       req = RESET_PC;
  end

  assign o_req_addr = {req[ADDR_W-1:2], 2'b00};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc     <= RESET_PC;
      r_f1_pc  <= RESET_PC;
      r_f1_vld <= 1'b0;
    end else if (!replay) begin
      r_f1_pc  <= o_req_addr;
      r_f1_vld <= 1'b1;
      r_pc     <= o_req_addr + ADDR_W'(4);
    end
  end

  // Wrong-path data in a redirect cycle is squashed.
  assign o_valid = r_f1_vld & ~i_redirect & ~rst;
  assign o_instr = o_valid ? i_res_data : NOP;
  assign o_pc    = rst ? RESET_PC : r_f1_pc;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: reset, stall replay, redirect, wrap, reset mid-stall.
module tb_instruction_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst, i_stall, i_redirect;
  logic [31:0] i_redirect_pc, o_req_addr, i_res_data, o_instr, o_pc;
  logic        o_valid;

  logic        rst2;
  logic [31:0] req2, res2, instr2, pc2;
  logic        vld2;

  int n_chk  = 0;
  int n_pass = 0;

  instruction_fetch #(.ADDR_W(32), .INSTR_W(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .i_stall(i_stall), .i_redirect(i_redirect),
    .i_redirect_pc(i_redirect_pc), .o_req_addr(o_req_addr), .i_res_data(i_res_data),
    .o_instr(o_instr), .o_pc(o_pc), .o_valid(o_valid)
  );

  instruction_fetch #(.ADDR_W(32), .INSTR_W(32), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk(clk), .rst(rst2), .i_stall(1'b0), .i_redirect(1'b0),
    .i_redirect_pc(32'h0), .o_req_addr(req2), .i_res_data(res2),
    .o_instr(instr2), .o_pc(pc2), .o_valid(vld2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memory: mem[k] = k+1
  always @(posedge clk) begin
    i_res_data <= {2'b00, o_req_addr[31:2]} + 32'd1;
    res2       <= {2'b00, req2[31:2]} + 32'd1;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", tag, act, exp);
    else n_pass++;
  endtask

  task automatic step(input logic r, input logic s, input logic rd, input logic [31:0] rpc);
    @(posedge clk); #1;
    rst = r; i_stall = s; i_redirect = rd; i_redirect_pc = rpc;
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                         input logic v, input logic [31:0] req);
    chk({tag, ".pc"},    o_pc, pc);
    chk({tag, ".instr"}, o_instr, ins);
    chk({tag, ".valid"}, {31'b0, o_valid}, {31'b0, v});
    chk({tag, ".req"},   o_req_addr, req);
  endtask

  initial begin
    rst = 1'b1; rst2 = 1'b1; i_stall = 1'b0; i_redirect = 1'b0; i_redirect_pc = '0;

    // 1: reset and first fetches
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk_out("rst", 32'h0, NOP, 0, 32'h0);
    step(0, 0, 0, 0);
    chk("boot.valid", {31'b0, o_valid}, 32'h0);
    chk("boot.req", o_req_addr, 32'h0);
    step(0, 0, 0, 0); chk_out("f0", 32'h0, 32'd1, 1, 32'h4);
    step(0, 0, 0, 0); chk_out("f4", 32'h4, 32'd2, 1, 32'h8);

    // 2: stall for 3 cycles while o_pc=8
    step(0, 1, 0, 0); chk_out("stall1", 32'h8, 32'd3, 1, 32'h8);
    step(0, 1, 0, 0); chk_out("stall2", 32'h8, 32'd3, 1, 32'h8);
    step(0, 1, 0, 0); chk_out("stall3", 32'h8, 32'd3, 1, 32'h8);
    step(0, 0, 0, 0); chk_out("release", 32'h8, 32'd3, 1, 32'hC);
    step(0, 0, 0, 0); chk_out("fC", 32'hC, 32'd4, 1, 32'h10);

    // 3: redirect back to 0, then redirect to 0x40 while o_pc=4
    step(0, 0, 1, 32'h0); chk_out("redir0", 32'h10, NOP, 0, 32'h0);
    step(0, 0, 0, 0);     chk_out("r0.f0", 32'h0, 32'd1, 1, 32'h4);
    step(0, 0, 1, 32'h40); chk_out("redir40", 32'h4, NOP, 0, 32'h40);
    step(0, 0, 0, 0);     chk_out("f40", 32'h40, 32'h11, 1, 32'h44);
    step(0, 0, 1, 32'h43); chk_out("redir43", 32'h44, NOP, 0, 32'h40);
    step(0, 0, 0, 0);     chk_out("f40b", 32'h40, 32'h11, 1, 32'h44);

    // 4: redirect and stall in the same cycle, stall held after
    step(0, 1, 1, 32'h80); chk_out("rd+st", 32'h44, NOP, 0, 32'h80);
    step(0, 1, 0, 0);     chk_out("st.hold", 32'h80, 32'h21, 1, 32'h80);

    // 6: reset during stall, bubble stall ignored, restart at RESET_PC
    step(1, 1, 0, 0);     chk_out("rst.stall", 32'h0, NOP, 0, 32'h0);
    step(0, 1, 0, 0);
    chk("rs.boot.valid", {31'b0, o_valid}, 32'h0);
    chk("rs.boot.req", o_req_addr, 32'h0);
    step(0, 0, 0, 0);     chk_out("rs.f0", 32'h0, 32'd1, 1, 32'h4);
    step(0, 0, 0, 0);     chk_out("rs.f4", 32'h4, 32'd2, 1, 32'h8);

    // 5: address wrap on second instance
    @(posedge clk); #1; rst2 = 1'b0; #1;
    chk("w.boot.valid", {31'b0, vld2}, 32'h0);
    chk("w.boot.req", req2, 32'hFFFF_FFF8);
    @(posedge clk); #2;
    chk("w.pcF8", pc2, 32'hFFFF_FFF8); chk("w.iF8", instr2, 32'h3FFF_FFFF);
    chk("w.vF8", {31'b0, vld2}, 32'h1); chk("w.reqFC", req2, 32'hFFFF_FFFC);
    @(posedge clk); #2;
    chk("w.pcFC", pc2, 32'hFFFF_FFFC); chk("w.iFC", instr2, 32'h4000_0000);
    chk("w.vFC", {31'b0, vld2}, 32'h1); chk("w.req0", req2, 32'h0);
    @(posedge clk); #2;
    chk("w.pc0", pc2, 32'h0); chk("w.i0", instr2, 32'd1);
    chk("w.v0", {31'b0, vld2}, 32'h1);
    @(posedge clk); #2;
    chk("w.pc4", pc2, 32'h4); chk("w.i4", instr2, 32'd2);
    chk("w.v4", {31'b0, vld2}, 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
